// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/completion port between the memory-access stage and the memory controller,
// plus the opcode-class, memctl and stall encodings shared by the stage and its users.
`ifndef LOAD
`define LOAD 7'b0000011
`endif
`ifndef SAVE
`define SAVE 7'b0100011
`endif
`ifndef ADDI
`define ADDI 7'b0010011
`endif
`ifndef MEM_NOP
`define MEM_NOP 2'd0
`endif
`ifndef MEM_LOAD
`define MEM_LOAD 2'd1
`endif
`ifndef MEM_SAVE
`define MEM_SAVE 2'd2
`endif
`ifndef MEM_BYTE
`define MEM_BYTE 2'd0
`endif
`ifndef MEM_HALF
`define MEM_HALF 2'd1
`endif
`ifndef MEM_WORD
`define MEM_WORD 2'd2
`endif
`ifndef STALL_MEM
`define STALL_MEM 3'd4
`endif

interface mem_access_unit_if;
    logic [1:0]  memctl_op;
    logic [1:0]  memctl_len;
    logic [31:0] memctl_addr;
    logic [31:0] memctl_data;
    logic        memctl_fin;
    logic [31:0] memctl_out;
    modport master (output memctl_op, memctl_len, memctl_addr, memctl_data, input memctl_fin, memctl_out);
    modport slave  (input memctl_op, memctl_len, memctl_addr, memctl_data, output memctl_fin, memctl_out);
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: registered EX->WB memory stage with a posted store buffer, a memctl-owning FSM,
// misalignment trapping and load sign/zero extension.
module mem_access_unit #(
    parameter int SB_DEPTH      = 4,
    parameter int MISALIGN_TRAP = 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              in_valid,
    input  logic              forward,
    input  logic [4:0]        rd_addr,
    input  logic [31:0]       rd_val,
    input  logic [6:0]        ins_type,
    input  logic [2:0]        ins_details,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_val,
    mem_access_unit_if.master mc,
    output logic [2:0]        stall,
    output logic              output_valid,
    output logic [4:0]        output_rd_addr,
    output logic [31:0]       output_rd_val,
    output logic [6:0]        output_ins_type,
    output logic              output_forward,
    output logic [4:0]        forward_rd_addr,
    output logic [31:0]       forward_rd_val,
    output logic              misalign,
    output logic              sb_empty
);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {IDLE, ST_BUSY, LD_BUSY} state_t;
    state_t      st_q, st_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0] sb_addr_q [SB_DEPTH];
    logic [31:0] sb_data_q [SB_DEPTH];
    logic [1:0]  sb_len_q  [SB_DEPTH];
    logic [1:0]  op_q, op_d, len_q, len_d;
    logic [31:0] maddr_q, maddr_d, mdata_q, mdata_d;
    logic [4:0]  ld_rd_q, ld_rd_d, wb_rd_q, wb_rd_d, fwd_rd_q, fwd_rd_d;
    logic [2:0]  ld_f3_q, ld_f3_d;
    logic        valid_q, valid_d, fwd_q, fwd_d, mis_q, mis_d;
    logic [31:0] wb_val_q, wb_val_d, fwd_val_q, fwd_val_d;
    logic [6:0]  wb_type_q, wb_type_d;
    logic        is_ld, is_st, mem_ld, mem_st, misal, trap, ld_go, st_ok, full, acc, enq, deq, fin;
    logic [1:0]  sz;
    logic [31:0] al_addr, ld_ext;

    assign fin     = mc.memctl_fin;
    assign is_ld   = ins_type == `LOAD;
    assign is_st   = ins_type == `SAVE;
    assign mem_ld  = is_ld && (ins_details inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    assign mem_st  = is_st && (ins_details inside {3'd0, 3'd1, 3'd2});
    assign sz      = ins_details[1:0];
    assign misal   = (sz == 2'd1 && mem_addr[0]) || (sz == 2'd2 && mem_addr[1:0] != 2'b00);
    assign trap    = (MISALIGN_TRAP != 0) && misal && (mem_ld || mem_st);
    assign al_addr = {mem_addr[31:2], (sz == 2'd2) ? 2'b00 : (sz == 2'd1) ? {mem_addr[1], 1'b0} : mem_addr[1:0]};
    assign ld_go   = mem_ld && !trap;
    assign st_ok   = mem_st && !trap;
    assign full    = count_q == CW'(SB_DEPTH);
    // loads hold EX until their own fin; a full buffer blocks stores even while it drains
    assign stall   = (in_valid && (!rdy_in || ((st_q == LD_BUSY) ? !fin : (ld_go || (st_ok && full))))) ? `STALL_MEM : 3'd0;
    assign acc     = in_valid && stall == 3'd0;
    assign enq     = acc && st_ok;
    assign deq     = st_q == ST_BUSY && fin;
    assign ld_ext  = (ld_f3_q[1:0] == 2'd0) ? {{24{~ld_f3_q[2] & mc.memctl_out[7]}}, mc.memctl_out[7:0]} :
                     (ld_f3_q[1:0] == 2'd1) ? {{16{~ld_f3_q[2] & mc.memctl_out[15]}}, mc.memctl_out[15:0]} :
                     mc.memctl_out;

    always_comb begin
        st_d      = st_q;
        head_d    = deq ? head_q + 1'b1 : head_q;
        tail_d    = enq ? tail_q + 1'b1 : tail_q;
        count_d   = count_q + CW'(enq) - CW'(deq);
        op_d      = op_q;
        len_d     = len_q;
        maddr_d   = maddr_q;
        mdata_d   = mdata_q;
        ld_rd_d   = ld_rd_q;
        ld_f3_d   = ld_f3_q;
        valid_d   = 1'b0;
        fwd_d     = 1'b0;
        mis_d     = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_val_d  = wb_val_q;
        wb_type_d = wb_type_q;
        fwd_rd_d  = fwd_rd_q;
        fwd_val_d = fwd_val_q;
        if (st_q == IDLE) begin
            if (in_valid && ld_go && count_q == '0) begin
                st_d    = LD_BUSY;
                op_d    = `MEM_LOAD;
                len_d   = sz;
                maddr_d = al_addr;
                mdata_d = 32'd0;
                ld_rd_d = rd_addr;
                ld_f3_d = ins_details;
            end else if (count_q != '0) begin
                st_d    = ST_BUSY;
                op_d    = `MEM_SAVE;
                len_d   = sb_len_q[head_q];
                maddr_d = sb_addr_q[head_q];
                mdata_d = sb_data_q[head_q];
            end
        end else if (fin) begin
            st_d = IDLE;
            op_d = `MEM_NOP;
        end
        if (st_q == LD_BUSY && fin) begin
            valid_d   = 1'b1;
            fwd_d     = 1'b1;
            wb_rd_d   = ld_rd_q;
            wb_val_d  = ld_ext;
            wb_type_d = `LOAD;
            fwd_rd_d  = ld_rd_q;
            fwd_val_d = ld_ext;
        end else if (acc) begin
            // every load/store class reaching here is a bubble: a posted store, a trap, or bad funct3
            valid_d   = 1'b1;
            mis_d     = trap;
            fwd_d     = (mem_st || trap) ? 1'b0 : forward;
            wb_rd_d   = (is_ld || is_st) ? 5'd0 : rd_addr;
            wb_val_d  = rd_val;
            wb_type_d = ins_type;
            fwd_rd_d  = (is_ld || is_st) ? 5'd0 : rd_addr;
            fwd_val_d = rd_val;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            st_q      <= IDLE;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            op_q      <= `MEM_NOP;
            len_q     <= `MEM_BYTE;
            maddr_q   <= 32'd0;
            mdata_q   <= 32'd0;
            ld_rd_q   <= 5'd0;
            ld_f3_q   <= 3'd0;
            valid_q   <= 1'b0;
            fwd_q     <= 1'b0;
            mis_q     <= 1'b0;
            wb_rd_q   <= 5'd0;
            wb_val_q  <= 32'd0;
            wb_type_q <= `ADDI;
            fwd_rd_q  <= 5'd0;
            fwd_val_q <= 32'd0;
        end else if (rdy_in) begin
            st_q      <= st_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            op_q      <= op_d;
            len_q     <= len_d;
            maddr_q   <= maddr_d;
            mdata_q   <= mdata_d;
            ld_rd_q   <= ld_rd_d;
            ld_f3_q   <= ld_f3_d;
            valid_q   <= valid_d;
            fwd_q     <= fwd_d;
            mis_q     <= mis_d;
            wb_rd_q   <= wb_rd_d;
            wb_val_q  <= wb_val_d;
            wb_type_q <= wb_type_d;
            fwd_rd_q  <= fwd_rd_d;
            fwd_val_q <= fwd_val_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in && enq) begin
            sb_addr_q[tail_q] <= al_addr;
            sb_data_q[tail_q] <= mem_val;
            sb_len_q[tail_q]  <= sz;
        end
    end

    assign mc.memctl_op     = op_q;
    assign mc.memctl_len    = len_q;
    assign mc.memctl_addr   = maddr_q;
    assign mc.memctl_data   = mdata_q;
    assign output_valid     = valid_q;
    assign output_rd_addr   = wb_rd_q;
    assign output_rd_val    = wb_val_q;
    assign output_ins_type  = wb_type_q;
    assign output_forward   = fwd_q;
    assign forward_rd_addr  = fwd_rd_q;
    assign forward_rd_val   = fwd_val_q;
    assign misalign         = mis_q;
    assign sb_empty         = count_q == '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed table-driven bench for mem_access_unit (SB_DEPTH=4, MISALIGN_TRAP=1),
// with the bench acting as the memory controller.
`ifndef LOAD
`define LOAD 7'b0000011
`endif
`ifndef SAVE
`define SAVE 7'b0100011
`endif
`ifndef ADDI
`define ADDI 7'b0010011
`endif
`ifndef MEM_NOP
`define MEM_NOP 2'd0
`endif
`ifndef MEM_LOAD
`define MEM_LOAD 2'd1
`endif
`ifndef MEM_SAVE
`define MEM_SAVE 2'd2
`endif
`ifndef MEM_BYTE
`define MEM_BYTE 2'd0
`endif
`ifndef MEM_HALF
`define MEM_HALF 2'd1
`endif
`ifndef MEM_WORD
`define MEM_WORD 2'd2
`endif
`ifndef STALL_MEM
`define STALL_MEM 3'd4
`endif

module tb_mem_access_unit;
    logic        clk_in, rst_in, rdy_in, in_valid, forward;
    logic [4:0]  rd_addr;
    logic [31:0] rd_val, mem_addr, mem_val;
    logic [6:0]  ins_type;
    logic [2:0]  ins_details;
    logic [2:0]  stall;
    logic        output_valid, output_forward, misalign, sb_empty;
    logic [4:0]  output_rd_addr, forward_rd_addr;
    logic [31:0] output_rd_val, forward_rd_val;
    logic [6:0]  output_ins_type;
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];

    mem_access_unit_if mc();

    mem_access_unit #(.SB_DEPTH(4), .MISALIGN_TRAP(1)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .in_valid(in_valid), .forward(forward),
        .rd_addr(rd_addr), .rd_val(rd_val), .ins_type(ins_type), .ins_details(ins_details),
        .mem_addr(mem_addr), .mem_val(mem_val), .mc(mc), .stall(stall),
        .output_valid(output_valid), .output_rd_addr(output_rd_addr), .output_rd_val(output_rd_val),
        .output_ins_type(output_ins_type), .output_forward(output_forward),
        .forward_rd_addr(forward_rd_addr), .forward_rd_val(forward_rd_val),
        .misalign(misalign), .sb_empty(sb_empty)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [6:0]  typ;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        fwd;
        logic [4:0]  e_rd;
        logic        e_fwd;
        logic        e_mis;
    } vec_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] mem;
        logic [31:0] exp;
        int          dly;
    } ld_t;

    vec_t pv[9];
    ld_t  lv[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] t, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] md, input logic [4:0] rd, input logic [31:0] rv, input logic fw);
        in_valid = v; ins_type = t; ins_details = f3; mem_addr = a;
        mem_val = md; rd_addr = rd; rd_val = rv; forward = fw;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            int w = 0;
            while (mc.memctl_op != `MEM_SAVE && w < 20) begin
                tick();
                w++;
            end
            chk("drain_op", mc.memctl_op, `MEM_SAVE);
            chk("drain_addr", mc.memctl_addr, exp_a.pop_front());
            chk("drain_data", mc.memctl_data, exp_d.pop_front());
            mc.memctl_fin = 1'b1;
            tick();
            mc.memctl_fin = 1'b0;
        end
    endtask

    initial begin
        pv[0] = '{`ADDI,        3'd0, 32'h0,   5'd5,  32'd7,        1'b1, 5'd5,  1'b1, 1'b0};
        pv[1] = '{7'b0110011,   3'd0, 32'h0,   5'd31, 32'hFFFFFFFF, 1'b0, 5'd31, 1'b0, 1'b0};
        pv[2] = '{`LOAD,        3'd2, 32'h202, 5'd7,  32'h11,       1'b1, 5'd0,  1'b0, 1'b1};
        pv[3] = '{`LOAD,        3'd1, 32'h101, 5'd8,  32'h22,       1'b1, 5'd0,  1'b0, 1'b1};
        pv[4] = '{`SAVE,        3'd1, 32'h103, 5'd9,  32'h33,       1'b1, 5'd0,  1'b0, 1'b1};
        pv[5] = '{`SAVE,        3'd2, 32'h201, 5'd9,  32'h44,       1'b1, 5'd0,  1'b0, 1'b1};
        pv[6] = '{`LOAD,        3'd3, 32'h0,   5'd6,  32'h55,       1'b1, 5'd0,  1'b1, 1'b0};
        pv[7] = '{`SAVE,        3'd4, 32'h0,   5'd2,  32'h66,       1'b0, 5'd0,  1'b0, 1'b0};
        pv[8] = '{`LOAD,        3'd5, 32'h101, 5'd4,  32'h77,       1'b1, 5'd0,  1'b0, 1'b1};
        lv[0] = '{3'd0, 32'h100, `MEM_BYTE, 32'h0000_0080, 32'hFFFF_FF80, 0};
        lv[1] = '{3'd4, 32'h100, `MEM_BYTE, 32'h0000_0080, 32'h0000_0080, 0};
        lv[2] = '{3'd1, 32'h100, `MEM_HALF, 32'h0000_8001, 32'hFFFF_8001, 1};
        lv[3] = '{3'd5, 32'h102, `MEM_HALF, 32'h0000_8001, 32'h0000_8001, 0};
        lv[4] = '{3'd2, 32'h104, `MEM_WORD, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2};
        lv[5] = '{3'd0, 32'h101, `MEM_BYTE, 32'h1234_567F, 32'h0000_007F, 0};
        lv[6] = '{3'd1, 32'h106, `MEM_HALF, 32'hFFFF_7FFF, 32'h0000_7FFF, 0};

        rst_in = 1'b1; rdy_in = 1'b1;
        mc.memctl_fin = 1'b0; mc.memctl_out = 32'd0;
        drive(1'b0, `ADDI, 3'd0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        #2;
        chk("rst_op", mc.memctl_op, `MEM_NOP);
        chk("rst_len", mc.memctl_len, `MEM_BYTE);
        chk("rst_addr", mc.memctl_addr, 32'd0);
        chk("rst_valid", output_valid, 1'b0);
        chk("rst_type", output_ins_type, `ADDI);
        chk("rst_sb_empty", sb_empty, 1'b1);
        chk("rst_stall", stall, 3'd0);
        tick();
        rst_in = 1'b0;

        for (int i = 0; i < 9; i++) begin
            drive(1'b1, pv[i].typ, pv[i].f3, pv[i].addr, 32'hA5A5_0000, pv[i].rd, pv[i].val, pv[i].fwd);
            @(negedge clk_in);
            chk($sformatf("pv%0d_stall", i), stall, 3'd0);
            tick();
            chk($sformatf("pv%0d_valid", i), output_valid, 1'b1);
            chk($sformatf("pv%0d_rd", i), output_rd_addr, pv[i].e_rd);
            chk($sformatf("pv%0d_fwd", i), output_forward, pv[i].e_fwd);
            chk($sformatf("pv%0d_fwd_rd", i), forward_rd_addr, pv[i].e_rd);
            chk($sformatf("pv%0d_mis", i), misalign, pv[i].e_mis);
            chk($sformatf("pv%0d_type", i), output_ins_type, pv[i].typ);
            chk($sformatf("pv%0d_op", i), mc.memctl_op, `MEM_NOP);
            chk($sformatf("pv%0d_sb_empty", i), sb_empty, 1'b1);
            if (pv[i].typ != `LOAD && pv[i].typ != `SAVE)
                chk($sformatf("pv%0d_val", i), output_rd_val, pv[i].val);
        end
        in_valid = 1'b0;
        tick();
        chk("mis_pulse_end", misalign, 1'b0);
        chk("idle_valid", output_valid, 1'b0);

        for (int i = 0; i < 7; i++) begin
            logic [4:0] rd;
            rd = 5'd10 + 5'(i);
            drive(1'b1, `LOAD, lv[i].f3, lv[i].addr, 32'd0, rd, 32'd0, 1'b0);
            @(negedge clk_in);
            chk($sformatf("ld%0d_stall_start", i), stall, `STALL_MEM);
            tick();
            chk($sformatf("ld%0d_op", i), mc.memctl_op, `MEM_LOAD);
            chk($sformatf("ld%0d_addr", i), mc.memctl_addr, lv[i].addr);
            chk($sformatf("ld%0d_len", i), mc.memctl_len, lv[i].len);
            for (int d = 0; d < lv[i].dly; d++) begin
                @(negedge clk_in);
                chk($sformatf("ld%0d_stall_wait", i), stall, `STALL_MEM);
                tick();
                chk($sformatf("ld%0d_op_held", i), mc.memctl_op, `MEM_LOAD);
            end
            mc.memctl_fin = 1'b1; mc.memctl_out = lv[i].mem;
            @(negedge clk_in);
            chk($sformatf("ld%0d_stall_fin", i), stall, 3'd0);
            tick();
            mc.memctl_fin = 1'b0; in_valid = 1'b0;
            chk($sformatf("ld%0d_valid", i), output_valid, 1'b1);
            chk($sformatf("ld%0d_rd", i), output_rd_addr, rd);
            chk($sformatf("ld%0d_val", i), output_rd_val, lv[i].exp);
            chk($sformatf("ld%0d_fwd", i), output_forward, 1'b1);
            chk($sformatf("ld%0d_fwd_val", i), forward_rd_val, lv[i].exp);
            chk($sformatf("ld%0d_type", i), output_ins_type, `LOAD);
            chk($sformatf("ld%0d_op_nop", i), mc.memctl_op, `MEM_NOP);
        end

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, `SAVE, 3'd2, 32'(i * 4), 32'hA000_0000 + 32'(i), 5'd3, 32'd0, 1'b1);
            @(negedge clk_in);
            chk($sformatf("sw%0d_stall", i), stall, 3'd0);
            tick();
            exp_a.push_back(32'(i * 4));
            exp_d.push_back(32'hA000_0000 + 32'(i));
            if (i == 0) begin
                chk("sw_bubble_valid", output_valid, 1'b1);
                chk("sw_bubble_rd", output_rd_addr, 5'd0);
                chk("sw_bubble_fwd", output_forward, 1'b0);
            end
        end
        drive(1'b1, `SAVE, 3'd2, 32'd16, 32'hA000_0004, 5'd3, 32'd0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_in);
            chk("sw4_stall_full", stall, `STALL_MEM);
            tick();
        end
        chk("full_op", mc.memctl_op, `MEM_SAVE);
        chk("full_addr", mc.memctl_addr, exp_a.pop_front());
        chk("full_data", mc.memctl_data, exp_d.pop_front());
        chk("full_len", mc.memctl_len, `MEM_WORD);
        chk("full_sb_empty", sb_empty, 1'b0);
        mc.memctl_fin = 1'b1;
        @(negedge clk_in);
        chk("sw4_stall_deq", stall, `STALL_MEM);
        tick();
        mc.memctl_fin = 1'b0;
        chk("post_fin_nop", mc.memctl_op, `MEM_NOP);
        @(negedge clk_in);
        chk("sw4_accept", stall, 3'd0);
        tick();
        in_valid = 1'b0;
        exp_a.push_back(32'd16);
        exp_d.push_back(32'hA000_0004);
        drain(4);
        for (int i = 5; i < 8; i++) begin
            drive(1'b1, `SAVE, 3'd2, 32'(i * 4), 32'hA000_0000 + 32'(i), 5'd3, 32'd0, 1'b1);
            @(negedge clk_in);
            chk($sformatf("sw%0d_stall", i), stall, 3'd0);
            tick();
            exp_a.push_back(32'(i * 4));
            exp_d.push_back(32'hA000_0000 + 32'(i));
        end
        in_valid = 1'b0;
        drain(3);
        chk("wrap_sb_empty", sb_empty, 1'b1);

        begin
            logic seen_save, done;
            seen_save = 1'b0; done = 1'b0;
            drive(1'b1, `SAVE, 3'd2, 32'h200, 32'h1234_5678, 5'd0, 32'd0, 1'b0);
            @(negedge clk_in);
            chk("swlw_sw_stall", stall, 3'd0);
            tick();
            drive(1'b1, `LOAD, 3'd2, 32'h200, 32'd0, 5'd9, 32'd0, 1'b0);
            for (int c = 0; c < 30 && !done; c++) begin
                if (mc.memctl_op == `MEM_SAVE && !seen_save) begin
                    chk("swlw_save_addr", mc.memctl_addr, 32'h200);
                    chk("swlw_save_data", mc.memctl_data, 32'h1234_5678);
                    mc.memctl_fin = 1'b1;
                    seen_save = 1'b1;
                end else if (mc.memctl_op == `MEM_LOAD) begin
                    chk("swlw_order", seen_save, 1'b1);
                    chk("swlw_load_addr", mc.memctl_addr, 32'h200);
                    mc.memctl_fin = 1'b1; mc.memctl_out = 32'hCAFE_BABE;
                    done = 1'b1;
                end
                @(negedge clk_in);
                chk("swlw_stall", stall, done ? 3'd0 : `STALL_MEM);
                tick();
                mc.memctl_fin = 1'b0;
            end
            in_valid = 1'b0;
            chk("swlw_done", done, 1'b1);
            chk("swlw_val", output_rd_val, 32'hCAFE_BABE);
            chk("swlw_rd", output_rd_addr, 5'd9);
            chk("swlw_fwd", output_forward, 1'b1);
        end

        drive(1'b1, `SAVE, 3'd2, 32'h300, 32'h55, 5'd0, 32'd0, 1'b0);
        @(negedge clk_in);
        chk("addi_sw_stall", stall, 3'd0);
        tick();
        in_valid = 1'b0;
        for (int w = 0; w < 10 && mc.memctl_op != `MEM_SAVE; w++) tick();
        chk("addi_busy_op", mc.memctl_op, `MEM_SAVE);
        drive(1'b1, `ADDI, 3'd0, 32'd0, 32'd0, 5'd5, 32'd7, 1'b1);
        @(negedge clk_in);
        chk("addi_stall", stall, 3'd0);
        tick();
        chk("addi_rd", output_rd_addr, 5'd5);
        chk("addi_val", output_rd_val, 32'd7);
        chk("addi_fwd_rd", forward_rd_addr, 5'd5);
        chk("addi_fwd", output_forward, 1'b1);
        chk("addi_drain_op", mc.memctl_op, `MEM_SAVE);
        chk("addi_drain_addr", mc.memctl_addr, 32'h300);
        rdy_in = 1'b0;
        drive(1'b1, `ADDI, 3'd0, 32'd0, 32'd0, 5'd3, 32'd9, 1'b1);
        mc.memctl_fin = 1'b1;
        @(negedge clk_in);
        chk("rdy0_stall", stall, `STALL_MEM);
        tick();
        chk("rdy0_valid_held", output_valid, 1'b1);
        chk("rdy0_rd_held", output_rd_addr, 5'd5);
        chk("rdy0_fin_ignored", mc.memctl_op, `MEM_SAVE);
        chk("rdy0_sb_held", sb_empty, 1'b0);
        rdy_in = 1'b1; in_valid = 1'b0;
        tick();
        mc.memctl_fin = 1'b0;
        chk("addi_sb_empty", sb_empty, 1'b1);
        chk("addi_op_nop", mc.memctl_op, `MEM_NOP);

        drive(1'b1, `LOAD, 3'd2, 32'h400, 32'd0, 5'd12, 32'd0, 1'b0);
        @(negedge clk_in);
        tick();
        in_valid = 1'b0;
        chk("rstld_op", mc.memctl_op, `MEM_LOAD);
        #2 rst_in = 1'b1;
        #1;
        chk("rstld_op_nop", mc.memctl_op, `MEM_NOP);
        chk("rstld_addr", mc.memctl_addr, 32'd0);
        chk("rstld_valid", output_valid, 1'b0);
        chk("rstld_rd", output_rd_addr, 5'd0);
        chk("rstld_val", output_rd_val, 32'd0);
        chk("rstld_type", output_ins_type, `ADDI);
        chk("rstld_fwd", output_forward, 1'b0);
        chk("rstld_fwd_rd", forward_rd_addr, 5'd0);
        chk("rstld_fwd_val", forward_rd_val, 32'd0);
        chk("rstld_mis", misalign, 1'b0);
        chk("rstld_sb_empty", sb_empty, 1'b1);
        chk("rstld_stall", stall, 3'd0);
        tick();
        rst_in = 1'b0;
        tick();
        chk("post_rst_op", mc.memctl_op, `MEM_NOP);
        chk("post_rst_sb_empty", sb_empty, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
